// File: rtl/mem_access_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_controller_if
//  Description : Shared client bus between the MemoryReader/MemoryWriter
//                clients and the memory access controller. It carries the
//                per-client request/grant pairs, the read/write strobes
//                with their address and data, and the busy/rd_data return
//                path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_controller_if #(
  parameter int NCLIENT = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);

  logic [NCLIENT-1:0] req;
  logic [NCLIENT-1:0] grant;
  logic               rd_enable;
  logic               wr_enable;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               busy;
  logic [DATA_W-1:0]  rd_data;

  // Client side: raises requests and strobes, watches grant/busy/rd_data
  modport master (
    output req,
    output rd_enable,
    output wr_enable,
    output rd_addr,
    output wr_addr,
    output wr_data,
    input  grant,
    input  busy,
    input  rd_data
  );

  // Controller side
  modport slave (
    input  req,
    input  rd_enable,
    input  wr_enable,
    input  rd_addr,
    input  wr_addr,
    input  wr_data,
    output grant,
    output busy,
    output rd_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_controller
//  Description : Memory-side end of the IMemory/IArbiter protocol. Arbitrates
//                NCLIENT requests into a registered one-hot grant, serves one
//                read or write per bus access against a 1-cycle-latency
//                synchronous SRAM and drives busy/rd_data back to the clients.
//                A sticky proto_err flags strobes seen without a grant or
//                read and write strobes asserted together.
//  Config      : define MEMCTRL_ROUND_ROBIN_EN for round-robin arbitration
//                starting at (last owner + 1) mod NCLIENT; undefined gives
//                fixed priority with the lowest index winning.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_controller #(
  parameter int NCLIENT     = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mem_access_controller_if.slave  bus,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  wire logic [DATA_W-1:0]  mem_rdata,
  output logic                    proto_err
);

  localparam int c_IDX_W = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int c_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_STATES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Strobe qualification: only a solid 1 counts, a floating or unknown
  // strobe from an idle client must never start an access.
  // --------------------------------------------------------------------------
  logic wr_strobe;
  logic rd_strobe;

  assign wr_strobe = (bus.wr_enable === 1'b1);
  assign rd_strobe = (bus.rd_enable === 1'b1);

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
  logic [NCLIENT-1:0] grant_q;
  logic [NCLIENT-1:0] grant_d;
  logic               found;
  logic [c_IDX_W-1:0] idx;
`ifdef MEMCTRL_ROUND_ROBIN_EN
  logic [c_IDX_W-1:0] last_q;
  logic [c_IDX_W-1:0] last_d;
`endif

  // Next grant: the owner keeps it while it still requests, otherwise the
  // grant moves straight to the next winner (or drops to zero) in this edge.
  always_comb begin
    grant_d = grant_q;
    found   = 1'b0;
    idx     = '0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    if (!(|(grant_q & bus.req))) begin
      grant_d = '0;
      for (int k = 0; k < NCLIENT; k++) begin
`ifdef MEMCTRL_ROUND_ROBIN_EN
        idx = c_IDX_W'((int'(last_q) + 1 + k) % NCLIENT);
`else
        idx = c_IDX_W'(k);
`endif
        if (!found && bus.req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
`ifdef MEMCTRL_ROUND_ROBIN_EN
          last_d       = idx;
`endif
        end
      end
    end
  end

  // Registered grant (and round-robin pointer when enabled)
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      last_q  <= c_IDX_W'(NCLIENT - 1);
`endif
    end else begin
      grant_q <= grant_d;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Access FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [c_CNT_W-1:0] wait_cnt_q;
  logic               is_read_q;
  logic               busy_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               proto_err_q;

  // IDLE samples the strobes, ACCESS pulses the SRAM, WAIT covers the SRAM
  // latency (read data captured at the end of the first WAIT cycle), and
  // RELEASE gives the client one cycle of busy=0 with stable rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      is_read_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_strobe || rd_strobe) begin
            state_q   <= S_ACCESS;
            busy_q    <= 1'b1;
            mem_en_q  <= 1'b1;
            // Write wins when both strobes are present
            mem_we_q  <= wr_strobe;
            is_read_q <= !wr_strobe;
            if (wr_strobe) begin
              mem_addr_q  <= bus.wr_addr;
              mem_wdata_q <= bus.wr_data;
            end else begin
              mem_addr_q  <= bus.rd_addr;
            end
            // Illegal use is still served, but remembered until reset
            if ((wr_strobe && rd_strobe) || (grant_q == '0)) begin
              proto_err_q <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          state_q    <= S_WAIT;
          mem_en_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          if (is_read_q && (wait_cnt_q == '0)) begin
            rd_data_q <= mem_rdata;
          end
          if (wait_cnt_q == c_WAIT_LAST) begin
            state_q <= S_RELEASE;
            busy_q  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + c_CNT_ONE;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_data_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_controller
//  Description : Self-checking bench for mem_access_controller. A behavioural
//                SRAM sits on the memory port; an independent reference
//                memory and an integer-level arbiter model supply expected
//                values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_controller;

  localparam int NCLIENT     = 2;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int WAIT_STATES = 1;

  typedef logic [NCLIENT-1:0] req_t;

  typedef struct {
    bit          wr;
    bit          rd;
    int          cl;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        proto_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_access_controller_if #(.NCLIENT(NCLIENT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mem_access_controller #(
    .NCLIENT(NCLIENT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  // Behavioural 1-cycle-latency SRAM on the memory port
  logic [15:0] sram    [0:65535];
  // Expected memory contents kept by the bench
  logic [15:0] ref_mem [0:65535];

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 3 + 32'h1000);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Arbiter reference: integer owner and last-owner
  int m_owner;
  int m_last;

  function automatic int bit_of(input req_t v, input int i);
    return (int'(v) >> i) & 1;
  endfunction

  task automatic model_arb(input req_t r);
    int c;
    if (m_owner >= 0 && bit_of(r, m_owner) == 1) return;
    m_owner = -1;
    for (int k = 0; k < NCLIENT; k++) begin
`ifdef MEMCTRL_ROUND_ROBIN_EN
      c = (m_last + 1 + k) % NCLIENT;
`else
      c = k;
`endif
      if (m_owner < 0 && bit_of(r, c) == 1) begin
        m_owner = c;
        m_last  = c;
      end
    end
  endtask

  function automatic logic [31:0] model_grant();
    return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus access as a client: optionally obtain a grant, strobe for one
  // cycle, check the SRAM pulse and the busy window length.
  task automatic do_access(input int cl, input bit wr, input bit rd,
                           input logic [15:0] addr, input logic [15:0] data,
                           input bit use_grant);
    int n;
    if (use_grant) begin
      bus_if.req = bus_if.req | req_t'(1 << cl);
      n = 0;
      do begin
        step();
        n++;
      end while (bit_of(bus_if.grant, cl) != 1 && n < 20);
      check("grant_wait", 32'(bit_of(bus_if.grant, cl)), 32'd1);
    end else begin
      step();
    end
    bus_if.wr_enable = wr;
    bus_if.rd_enable = rd;
    bus_if.wr_addr   = addr;
    bus_if.rd_addr   = addr;
    bus_if.wr_data   = data;
    step();
    bus_if.wr_enable = 1'b0;
    bus_if.rd_enable = 1'b0;
    check("access_en",   32'(mem_en),   32'd1);
    check("access_we",   32'(mem_we),   32'(wr));
    check("access_addr", 32'(mem_addr), 32'(addr));
    if (wr) check("access_wdata", 32'(mem_wdata), 32'(data));
    n = 0;
    while (bus_if.busy === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("busy_len", 32'(n), 32'(1 + WAIT_STATES));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [6];
    logic [15:0] exp_rd;
    bit          exp_err;
    int          cl;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;

    for (int a = 0; a < 65536; a++) begin
      sram[a]    = init_val(a);
      ref_mem[a] = init_val(a);
    end

    tbl[0] = '{wr: 1'b0, rd: 1'b1, cl: 1, addr: 16'd5, data: 16'h0000, exp_rd: 16'hA5A5, exp_err: 1'b0};
    tbl[1] = '{wr: 1'b1, rd: 1'b0, cl: 0, addr: 16'd6, data: 16'h1234, exp_rd: 16'hA5A5, exp_err: 1'b0};
    tbl[2] = '{wr: 1'b0, rd: 1'b1, cl: 0, addr: 16'd6, data: 16'h0000, exp_rd: 16'h1234, exp_err: 1'b0};
    tbl[3] = '{wr: 1'b0, rd: 1'b1, cl: 1, addr: 16'd7, data: 16'h0000, exp_rd: 16'h1015, exp_err: 1'b0};
    tbl[4] = '{wr: 1'b1, rd: 1'b0, cl: 1, addr: 16'd5, data: 16'hBEEF, exp_rd: 16'h1015, exp_err: 1'b0};
    tbl[5] = '{wr: 1'b0, rd: 1'b1, cl: 0, addr: 16'd5, data: 16'h0000, exp_rd: 16'hBEEF, exp_err: 1'b0};

    bus_if.req       = '0;
    bus_if.rd_enable = 1'b0;
    bus_if.wr_enable = 1'b0;
    bus_if.rd_addr   = '0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_grant", 32'(bus_if.grant),   32'd0);
    check("rst_busy",  32'(bus_if.busy),    32'd0);
    check("rst_rd",    32'(bus_if.rd_data), 32'd0);
    check("rst_err",   32'(proto_err),      32'd0);
    check("rst_memen", 32'(mem_en),         32'd0);
    rst = 1'b0;
    step();
    check("idle_grant", 32'(bus_if.grant), 32'd0);

    // Random request patterns against the arbiter model
    m_owner = -1;
    m_last  = NCLIENT - 1;
    for (int i = 0; i < 150; i++) begin
      bus_if.req = req_t'($urandom_range(0, (1 << NCLIENT) - 1));
      model_arb(bus_if.req);
      step();
      check("arb_rand", 32'(bus_if.grant), model_grant());
    end
    bus_if.req = '0;
    model_arb(bus_if.req);
    step();
    check("arb_release", 32'(bus_if.grant), 32'd0);

    // Write A5A5 to addr 5 through client 1
    bus_if.req = 2'b10;
    step();
    check("grant_c1", 32'(bus_if.grant), 32'h2);
    do_access(1, 1'b1, 1'b0, 16'd5, 16'hA5A5, 1'b1);
    ref_mem[5] = 16'hA5A5;
    check("wr_err", 32'(proto_err), 32'd0);
    bus_if.req = '0;
    step();
    check("grant_drop", 32'(bus_if.grant), 32'd0);

    // Table of single accesses
    foreach (tbl[i]) begin
      do_access(tbl[i].cl, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, 1'b1);
      if (tbl[i].wr) ref_mem[tbl[i].addr] = tbl[i].data;
      check("tbl_rd_data", 32'(bus_if.rd_data), 32'(tbl[i].exp_rd));
      check("tbl_err",     32'(proto_err),      32'(tbl[i].exp_err));
      bus_if.req = '0;
      step();
      check("tbl_grant_drop", 32'(bus_if.grant), 32'd0);
    end
    exp_rd = 16'hBEEF;

    // rd_data holds across idle cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_hold", 32'(bus_if.rd_data), 32'(exp_rd));
    end

    // Both clients request continuously: the first owner keeps the grant
    bus_if.req = 2'b11;
    step();
    check("dual_grant", 32'(bus_if.grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      do_access(0, 1'b0, 1'b1, 16'(6 + i), 16'h0000, 1'b1);
      exp_rd = ref_mem[6 + i];
      check("dual_rd",    32'(bus_if.rd_data), 32'(exp_rd));
      check("dual_owner", 32'(bus_if.grant),   32'h1);
    end
    bus_if.req = '0;
    step();
    check("dual_drop", 32'(bus_if.grant), 32'd0);

    // Random accesses checked against the reference memory
    for (int i = 0; i < 30; i++) begin
      cl   = int'($urandom_range(0, NCLIENT - 1));
      wr   = 1'($urandom_range(0, 1));
      addr = 16'(16 + $urandom_range(0, 15));
      data = 16'($urandom);
      do_access(cl, wr, !wr, addr, data, 1'b1);
      if (wr) ref_mem[addr] = data;
      else    exp_rd = ref_mem[addr];
      check("rand_rd_data", 32'(bus_if.rd_data), 32'(exp_rd));
      check("rand_err",     32'(proto_err),      32'd0);
      bus_if.req = '0;
      step();
      check("rand_grant_drop", 32'(bus_if.grant), 32'd0);
    end

    // Both strobes together: write wins, proto_err is sticky
    exp_err = 1'b1;
    do_access(0, 1'b1, 1'b1, 16'd40, 16'hC3C3, 1'b1);
    ref_mem[40] = 16'hC3C3;
    check("both_rd_keep", 32'(bus_if.rd_data), 32'(exp_rd));
    check("both_err",     32'(proto_err),      32'(exp_err));
    do_access(0, 1'b0, 1'b1, 16'd40, 16'h0000, 1'b1);
    exp_rd = ref_mem[40];
    check("both_readback", 32'(bus_if.rd_data), 32'(exp_rd));
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky", 32'(proto_err), 32'(exp_err));
    end
    bus_if.req = '0;
    step();

    // Reset in the middle of an access
    bus_if.req = 2'b01;
    step();
    check("rst_mid_grant", 32'(bus_if.grant), 32'h1);
    bus_if.wr_enable = 1'b1;
    bus_if.wr_addr   = 16'd9;
    bus_if.wr_data   = 16'h7777;
    step();
    bus_if.wr_enable = 1'b0;
    check("rst_mid_busy_a", 32'(bus_if.busy), 32'd1);
    step();
    check("rst_mid_busy_w", 32'(bus_if.busy), 32'd1);
    rst        = 1'b1;
    bus_if.req = '0;
    step();
    rst = 1'b0;
    check("rst_mid_busy",  32'(bus_if.busy),    32'd0);
    check("rst_mid_grant0", 32'(bus_if.grant),  32'd0);
    check("rst_mid_rd",    32'(bus_if.rd_data), 32'd0);
    check("rst_mid_err",   32'(proto_err),      32'd0);
    do_access(0, 1'b0, 1'b1, 16'd10, 16'h0000, 1'b1);
    check("post_rst_rd",  32'(bus_if.rd_data), 32'(ref_mem[10]));
    check("post_rst_err", 32'(proto_err),      32'd0);
    bus_if.req = '0;
    step();

    // Strobe without a grant: served, but flagged
    do_access(0, 1'b0, 1'b1, 16'd11, 16'h0000, 1'b0);
    check("nogrant_rd",  32'(bus_if.rd_data), 32'(ref_mem[11]));
    check("nogrant_err", 32'(proto_err),      32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
